pipe_reg_hs: RTL and testbench

- Parametrised, generic successor to the fixed IF/ID stage register; usable between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a PC word and an instruction/payload word using a valid/ready handshake instead of a bare enable.
- Internal 2-entry skid buffer gives full throughput (1 item/cycle) with no combinational path from out_ready to in_ready.
- Adds a synchronous flush for branch/exception squash.

---
 rtl/pipe_reg_hs.sv | 207 ++++++++++++++++++++
 tb/tb_pipe_reg_hs.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_hs.sv
// -----------------------------------------------------------------------------
// pipe_reg_hs
//
// Generic pipeline stage register carrying a PC word and an instruction /
// payload word across a valid/ready handshake. It can sit between any two
// pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// Storage is a 2-entry skid buffer:
//   M - main register, always drives out_pc / out_instr
//   S - skid register, catches the item accepted while M is stalled
// The buffer sustains 1 item/cycle. in_ready is decoded from the state flops
// only, so there is no combinational path from out_ready to in_ready.
//
// flush squashes every held entry synchronously and has priority over both
// handshakes. rst is asynchronous and active-low. Its release is expected to
// be synchronised to clk outside this block.
//
// Optional feature (macro PIPE_STALL_CNT_EN):
//   Adds parameter CNT_W and output stall_cnt. stall_cnt is a saturating
//   count of cycles with out_valid=1 and out_ready=0. Only rst clears it;
//   flush leaves it unchanged.
//
// Parameters:
//   N      instruction/payload width          (default 32)
//   PC_W   PC width                           (default 64)
//   CNT_W  stall-counter width, PIPE_STALL_CNT_EN builds only (default 16)
//
// Ports:
//   clk        in           clock, rising edge
//   rst        in           asynchronous reset, active-low
//   flush      in           synchronous squash of all held entries
//   in_valid   in           upstream holds a valid item
//   in_ready   out          stage can accept an item this cycle
//   in_pc      in  [PC_W]   incoming PC
//   in_instr   in  [N]      incoming instruction/payload
//   out_valid  out          out_pc/out_instr hold a valid item
//   out_ready  in           downstream accepts the item this cycle
//   out_pc     out [PC_W]   held PC (register M)
//   out_instr  out [N]      held instruction/payload (register M)
//   stall_cnt  out [CNT_W]  backpressure stall count (PIPE_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module pipe_reg_hs #(
  parameter int unsigned N     = 32,
  parameter int unsigned PC_W  = 64
`ifdef PIPE_STALL_CNT_EN
  ,parameter int unsigned CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [N-1:0]    in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [N-1:0]    out_instr
`ifdef PIPE_STALL_CNT_EN
  ,output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PC_W-1:0] m_pc_q,    m_pc_d;
  logic [N-1:0]    m_instr_q, m_instr_d;
  logic [PC_W-1:0] s_pc_q,    s_pc_d;
  logic [N-1:0]    s_instr_q, s_instr_d;

  // Per-register valid bits, decoded from the state flops.
  logic m_vld;
  logic s_vld;

  logic in_fire;
  logic out_fire;

  assign m_vld    = (state_q != EMPTY);
  assign s_vld    = (state_q == TWO);
  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and data-path next values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    m_pc_d    = m_pc_q;
    m_instr_d = m_instr_q;
    s_pc_d    = s_pc_q;
    s_instr_d = s_instr_q;

    if (flush) begin
      // Squash: an item accepted in this cycle is dropped. An item read
      // downstream in this cycle has already been consumed.
      state_d   = EMPTY;
      m_pc_d    = '0;
      m_instr_d = '0;
      s_pc_d    = '0;
      s_instr_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            m_pc_d    = in_pc;
            m_instr_d = in_instr;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            // M drains and refills in the same cycle. No skid is needed.
            m_pc_d    = in_pc;
            m_instr_d = in_instr;
          end else if (in_fire) begin
            // M is stalled. Park the new item behind it.
            state_d   = TWO;
            s_pc_d    = in_pc;
            s_instr_d = in_instr;
          end else if (out_fire) begin
            state_d   = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d   = ONE;
            m_pc_d    = s_pc_q;
            m_instr_d = s_instr_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data registers M and S
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc_q    <= '0;
      m_instr_q <= '0;
      s_pc_q    <= '0;
      s_instr_q <= '0;
    end else begin
      m_pc_q    <= m_pc_d;
      m_instr_q <= m_instr_d;
      s_pc_q    <= s_pc_d;
      s_instr_q <= s_instr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (state flops only on the handshake side)
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = m_vld;
    in_ready  = ~s_vld;
    out_pc    = m_pc_q;
    out_instr = m_instr_q;
  end

`ifdef PIPE_STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating backpressure stall counter. Only rst clears it.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_hs.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_hs
//
// Directed test of pipe_reg_hs with N=32 and PC_W=64. Inputs change 1 time
// unit after a rising edge. Outputs are sampled at that point, after the
// edge has settled. When PIPE_STALL_CNT_EN is defined, the DUT is built with
// CNT_W=3 and the saturating stall counter is also exercised.
// -----------------------------------------------------------------------------
module tb_pipe_reg_hs;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
`ifdef PIPE_STALL_CNT_EN
  logic [2:0]  stall_cnt;
`endif

  int unsigned checks;
  int unsigned errors;

  pipe_reg_hs #(
    .N    (32),
    .PC_W (64)
`ifdef PIPE_STALL_CNT_EN
    ,.CNT_W(3)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
`ifdef PIPE_STALL_CNT_EN
    ,.stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;

    // ---------------- reset state
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_pc",    out_pc,             64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // ---------------- streaming, out_ready=1
    out_ready = 1'b1;
    push(64'h1000, 32'h0050_0093);
    tick();
    chk("str0_valid", {63'd0, out_valid}, 64'd1);
    chk("str0_pc",    out_pc,             64'h1000);
    chk("str0_instr", {32'd0, out_instr}, 64'h0050_0093);
    chk("str0_ready", {63'd0, in_ready},  64'd1);
    push(64'h1004, 32'h0060_0113);
    tick();
    chk("str1_valid", {63'd0, out_valid}, 64'd1);
    chk("str1_pc",    out_pc,             64'h1004);
    chk("str1_instr", {32'd0, out_instr}, 64'h0060_0113);
    push(64'h1008, 32'h0070_0193);
    tick();
    chk("str2_valid", {63'd0, out_valid}, 64'd1);
    chk("str2_pc",    out_pc,             64'h1008);
    chk("str2_instr", {32'd0, out_instr}, 64'h0070_0193);
    push(64'h100C, 32'h0080_0213);
    tick();
    chk("str3_valid", {63'd0, out_valid}, 64'd1);
    chk("str3_pc",    out_pc,             64'h100C);
    chk("str3_instr", {32'd0, out_instr}, 64'h0080_0213);
    in_valid = 1'b0;
    tick();
    chk("str_drain_valid", {63'd0, out_valid}, 64'd0);

    // ---------------- backpressure / skid
    out_ready = 1'b0;
    push(64'h2000, 32'hAAAA_0001);
    tick();
    chk("bp_a_pc",    out_pc,            64'h2000);
    chk("bp_a_ready", {63'd0, in_ready}, 64'd1);
    push(64'h2004, 32'hBBBB_0002);
    tick();
    chk("bp_two_ready", {63'd0, in_ready},  64'd0);
    chk("bp_two_pc",    out_pc,             64'h2000);
    chk("bp_two_instr", {32'd0, out_instr}, 64'hAAAA_0001);
    push(64'h2008, 32'hCCCC_0003);
    tick();
    chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_hold_pc",    out_pc,            64'h2000);
    out_ready = 1'b1;
    tick();
    chk("bp_b_pc",    out_pc,             64'h2004);
    chk("bp_b_instr", {32'd0, out_instr}, 64'hBBBB_0002);
    chk("bp_b_ready", {63'd0, in_ready},  64'd1);
    tick();
    chk("bp_c_pc",    out_pc,             64'h2008);
    chk("bp_c_instr", {32'd0, out_instr}, 64'hCCCC_0003);
    chk("bp_c_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", {63'd0, out_valid}, 64'd0);

    // ---------------- flush in TWO with D presented
    out_ready = 1'b0;
    push(64'h3010, 32'h1111_0010);
    tick();
    push(64'h3014, 32'h1111_0014);
    tick();
    chk("fl_pre_ready", {63'd0, in_ready}, 64'd0);
    push(64'h3000, 32'hDDDD_3000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ready", {63'd0, in_ready},  64'd1);
    chk("fl_pc",    out_pc,             64'd0);
    chk("fl_instr", {32'd0, out_instr}, 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_after_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_after_pc",    out_pc,             64'd0);

    // ---------------- simultaneous in/out in ONE
    out_ready = 1'b0;
    push(64'h4000, 32'h4444_0000);
    tick();
    chk("sim_m_pc", out_pc, 64'h4000);
    push(64'h4004, 32'h4444_0004);
    out_ready = 1'b1;
    tick();
    chk("sim_pc",    out_pc,             64'h4004);
    chk("sim_valid", {63'd0, out_valid}, 64'd1);
    chk("sim_ready", {63'd0, in_ready},  64'd1);
    in_valid = 1'b0;
    tick();
    chk("sim_drain_valid", {63'd0, out_valid}, 64'd0);

    // ---------------- asynchronous reset in TWO, between edges
    out_ready = 1'b0;
    push(64'h6000, 32'h6666_0000);
    tick();
    push(64'h6004, 32'h6666_0004);
    tick();
    in_valid = 1'b0;
    chk("ar_pre_ready", {63'd0, in_ready}, 64'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_ready", {63'd0, in_ready},  64'd1);
    chk("ar_pc",    out_pc,             64'd0);
    chk("ar_instr", {32'd0, out_instr}, 64'd0);
`ifdef PIPE_STALL_CNT_EN
    chk("ar_stall_cnt", {61'd0, stall_cnt}, 64'd0);
`endif
    #2;
    rst = 1'b1;
    push(64'h5000, 32'h5555_0000);
    tick();
    chk("ar_first_valid", {63'd0, out_valid}, 64'd1);
    chk("ar_first_pc",    out_pc,             64'h5000);
    chk("ar_first_ready", {63'd0, in_ready},  64'd1);
    in_valid = 1'b0;

`ifdef PIPE_STALL_CNT_EN
    // ---------------- stall counter, CNT_W=3
    // The push edge saw state EMPTY, so the count starts at 0 here.
    chk("sc_start", {61'd0, stall_cnt}, 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("sc_five", {61'd0, stall_cnt}, 64'd5);
    for (int i = 0; i < 5; i++) tick();
    chk("sc_sat", {61'd0, stall_cnt}, 64'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sc_flush_keep",  {61'd0, stall_cnt}, 64'd7);
    chk("sc_flush_valid", {63'd0, out_valid}, 64'd0);
    tick();
    chk("sc_idle_keep", {61'd0, stall_cnt}, 64'd7);
    #2;
    rst = 1'b0;
    #1;
    chk("sc_reset", {61'd0, stall_cnt}, 64'd0);
    #2;
    rst = 1'b1;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
